// File: rtl/lc3b_types.sv
// Shared LC-3b widths plus the L1->L2 arbiter grant and state encodings.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_block;

   // Which L1 owns (or last owned) the L2 port.
   typedef enum logic {
      ARB_I = 1'b0,
      ARB_D = 1'b1
   } arb_sel_t;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RESPOND
   } arb_state_t;

endpackage

// File: rtl/l2_arbiter_rr.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
module l2_arbiter_rr
   import lc3b_types::*;
(
   input  logic     req_i,
   input  logic     req_d,
   input  arb_sel_t last_grant,
   output logic     grant_valid,
   output arb_sel_t grant_sel
);

   // A lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      grant_valid = req_i | req_d;
      grant_sel   = ARB_I;
      if (req_i && req_d)
         grant_sel = (last_grant == ARB_I) ? ARB_D : ARB_I;
      else if (req_d)
         grant_sel = ARB_D;
   end

endmodule

// File: rtl/l2_arbiter.sv
// Serialises I-cache and D-cache line requests onto the single L2 port.
// One transaction at a time: grant (IDLE) -> SERVE_x until L2 resp -> RESPOND.
module l2_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH  = $bits(lc3b_word),
   parameter int BLOCK_WIDTH = $bits(lc3b_block),
   parameter int OFFSET_BITS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0]  icache_pmem_address,
   output logic [BLOCK_WIDTH-1:0] icache_pmem_rdata,
   output logic                   icache_pmem_resp,
   input  logic                   dcache_pmem_read,
   input  logic                   dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0]  dcache_pmem_address,
   input  logic [BLOCK_WIDTH-1:0] dcache_pmem_wdata,
   output logic [BLOCK_WIDTH-1:0] dcache_pmem_rdata,
   output logic                   dcache_pmem_resp,
   output logic                   l2arb_mem_read,
   output logic                   l2arb_mem_write,
   output logic [ADDR_WIDTH-1:0]  l2arb_mem_address,
   output logic [BLOCK_WIDTH-1:0] l2arb_mem_wdata,
   input  logic [BLOCK_WIDTH-1:0] l2arb_mem_rdata,
   input  logic                   l2arb_mem_resp
);

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   arb_state_t             state, state_nxt;
   arb_sel_t               last_grant;
   arb_sel_t               grant_sel;
   logic                   grant_valid;
   logic                   load;
   logic                   op_write_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [BLOCK_WIDTH-1:0] wdata_q;
   logic [BLOCK_WIDTH-1:0] i_rdata_q;
   logic [BLOCK_WIDTH-1:0] d_rdata_q;

   l2_arbiter_rr u_rr (
      .req_i       (icache_pmem_read),
      .req_d       (dcache_pmem_read | dcache_pmem_write),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs; L2 request only while serving.
   always_comb begin
      state_nxt        = state;
      load             = 1'b0;
      l2arb_mem_read   = 1'b0;
      l2arb_mem_write  = 1'b0;
      icache_pmem_resp = 1'b0;
      dcache_pmem_resp = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               load      = 1'b1;
               state_nxt = (grant_sel == ARB_I) ? SERVE_I : SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            l2arb_mem_read  = ~op_write_q;
            l2arb_mem_write = op_write_q;
            if (l2arb_mem_resp) state_nxt = RESPOND;
         end
         RESPOND: begin
            // last_grant was updated at grant time, so it names the owner.
            icache_pmem_resp = (last_grant == ARB_I);
            dcache_pmem_resp = (last_grant == ARB_D);
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture at grant, response line capture on L2 completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= ARB_D;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (load) begin
            last_grant <= grant_sel;
            if (grant_sel == ARB_I) begin
               addr_q     <= icache_pmem_address & LINE_MASK;
               op_write_q <= 1'b0;
            end else begin
               addr_q     <= dcache_pmem_address & LINE_MASK;
               wdata_q    <= dcache_pmem_wdata;
               // read+write together is a writeback.
               op_write_q <= dcache_pmem_write;
            end
         end
         if (l2arb_mem_resp && state == SERVE_I) i_rdata_q <= l2arb_mem_rdata;
         if (l2arb_mem_resp && state == SERVE_D) d_rdata_q <= l2arb_mem_rdata;
      end
   end

   assign l2arb_mem_address = addr_q;
   assign l2arb_mem_wdata   = wdata_q;
   assign icache_pmem_rdata = i_rdata_q;
   assign dcache_pmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with a simple fixed-latency L2 responder.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         icache_pmem_read;
   logic [15:0]  icache_pmem_address;
   logic [127:0] icache_pmem_rdata;
   logic         icache_pmem_resp;
   logic         dcache_pmem_read;
   logic         dcache_pmem_write;
   logic [15:0]  dcache_pmem_address;
   logic [127:0] dcache_pmem_wdata;
   logic [127:0] dcache_pmem_rdata;
   logic         dcache_pmem_resp;
   logic         l2arb_mem_read;
   logic         l2arb_mem_write;
   logic [15:0]  l2arb_mem_address;
   logic [127:0] l2arb_mem_wdata;
   logic [127:0] l2arb_mem_rdata;
   logic         l2arb_mem_resp;

   l2_arbiter dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .icache_pmem_read    (icache_pmem_read),
      .icache_pmem_address (icache_pmem_address),
      .icache_pmem_rdata   (icache_pmem_rdata),
      .icache_pmem_resp    (icache_pmem_resp),
      .dcache_pmem_read    (dcache_pmem_read),
      .dcache_pmem_write   (dcache_pmem_write),
      .dcache_pmem_address (dcache_pmem_address),
      .dcache_pmem_wdata   (dcache_pmem_wdata),
      .dcache_pmem_rdata   (dcache_pmem_rdata),
      .dcache_pmem_resp    (dcache_pmem_resp),
      .l2arb_mem_read      (l2arb_mem_read),
      .l2arb_mem_write     (l2arb_mem_write),
      .l2arb_mem_address   (l2arb_mem_address),
      .l2arb_mem_wdata     (l2arb_mem_wdata),
      .l2arb_mem_rdata     (l2arb_mem_rdata),
      .l2arb_mem_resp      (l2arb_mem_resp)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           lat   = 3;
   logic [127:0] l2_data;
   int           l2_cnt = 0;

   // Monitor state, all updated on the falling edge.
   int           cyc = 0, rd_cyc = 0, wr_cyc = 0, i_pul = 0, d_pul = 0;
   int           lr_cyc = 0, dr_cyc = 0, viol = 0;
   logic [15:0]  mon_addr = '0;
   logic [127:0] mon_wdata = '0;

   // L2 model: answers after 'lat' request cycles with a one-cycle resp.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         l2_cnt         <= 0;
         l2arb_mem_resp <= 1'b0;
      end else if ((l2arb_mem_read || l2arb_mem_write) && !l2arb_mem_resp) begin
         if (l2_cnt + 1 == lat) begin
            l2arb_mem_resp  <= 1'b1;
            l2arb_mem_rdata <= l2_data;
            l2_cnt          <= 0;
         end else begin
            l2_cnt <= l2_cnt + 1;
         end
      end else begin
         l2arb_mem_resp <= 1'b0;
      end
   end

   // Mid-cycle observer of the L2 side and L1 response pulses.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (l2arb_mem_read)  rd_cyc <= rd_cyc + 1;
      if (l2arb_mem_write) wr_cyc <= wr_cyc + 1;
      if (l2arb_mem_read || l2arb_mem_write) begin
         mon_addr  <= l2arb_mem_address;
         mon_wdata <= l2arb_mem_wdata;
      end
      if (l2arb_mem_resp) lr_cyc <= cyc;
      if (icache_pmem_resp) i_pul <= i_pul + 1;
      if (dcache_pmem_resp) begin
         d_pul  <= d_pul + 1;
         dr_cyc <= cyc;
      end
      if ((icache_pmem_resp || dcache_pmem_resp) && (l2arb_mem_read || l2arb_mem_write))
         viol <= viol + 1;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_resp(output logic gi, output logic gd);
      logic seen;
      seen = 1'b0;
      gi   = 1'b0;
      gd   = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         tick();
         if (icache_pmem_resp || dcache_pmem_resp) begin
            seen = 1'b1;
            gi   = icache_pmem_resp;
            gd   = dcache_pmem_resp;
         end
      end
      if (!seen) chk("resp_timeout", 128'd0, 128'd1);
   endtask

   task automatic wait_req();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 32 && !seen; k++) begin
         tick();
         seen = l2arb_mem_read | l2arb_mem_write;
      end
      if (!seen) chk("req_timeout", 128'd0, 128'd1);
   endtask

   localparam logic [127:0] A5 = {16{8'hA5}};
   localparam logic [127:0] W0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] W1 = {16{8'h11}};
   localparam logic [127:0] W2 = {16{8'h22}};
   localparam logic [127:0] D5 = {16{8'h5A}};
   localparam logic [127:0] C3 = {16{8'hC3}};

   initial begin
      logic gi, gd;
      logic [3:0] seq;
      int b_rd, b_wr, b_i, b_d, b_v;

      rst_n = 1'b0;
      icache_pmem_read = 1'b0; icache_pmem_address = '0;
      dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
      dcache_pmem_address = '0; dcache_pmem_wdata = '0;
      l2_data = '0;
      tick(); tick();

      // Reset state
      chk("rst_ctrl", 128'({l2arb_mem_read, l2arb_mem_write, icache_pmem_resp, dcache_pmem_resp}), 128'd0);
      chk("rst_addr", 128'(l2arb_mem_address), 128'd0);
      chk("rst_wdata", l2arb_mem_wdata, 128'd0);
      chk("rst_irdata", icache_pmem_rdata, 128'd0);
      chk("rst_drdata", dcache_pmem_rdata, 128'd0);
      rst_n = 1'b1;
      tick();

      // I-only read, L2 latency 3
      lat = 3; l2_data = A5;
      b_rd = rd_cyc; b_i = i_pul; b_d = d_pul;
      icache_pmem_read = 1'b1; icache_pmem_address = 16'h1234;
      wait_resp(gi, gd);
      chk("t1_gi", 128'(gi), 128'd1);
      chk("t1_irdata", icache_pmem_rdata, A5);
      icache_pmem_read = 1'b0;
      tick();
      chk("t1_addr", 128'(mon_addr), 128'h1230);
      chk("t1_rd_cycles", 128'(rd_cyc - b_rd), 128'd3);
      chk("t1_i_pulses", 128'(i_pul - b_i), 128'd1);
      chk("t1_d_pulses", 128'(d_pul - b_d), 128'd0);
      chk("t1_iresp_low", 128'(icache_pmem_resp), 128'd0);
      chk("t1_irdata_hold", icache_pmem_rdata, A5);

      // D write, L2 latency 2
      lat = 2; l2_data = W2;
      b_rd = rd_cyc; b_wr = wr_cyc; b_d = d_pul;
      dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h2008; dcache_pmem_wdata = W0;
      wait_resp(gi, gd);
      chk("t2_gd", 128'(gd), 128'd1);
      dcache_pmem_write = 1'b0;
      tick();
      chk("t2_addr", 128'(mon_addr), 128'h2000);
      chk("t2_wdata", mon_wdata, W0);
      chk("t2_wr_cycles", 128'(wr_cyc - b_wr), 128'd2);
      chk("t2_no_read", 128'(rd_cyc - b_rd), 128'd0);
      chk("t2_resp_delay", 128'(dr_cyc - lr_cyc), 128'd1);
      chk("t2_d_pulses", 128'(d_pul - b_d), 128'd1);

      // D read and write together -> single write
      lat = 1;
      b_rd = rd_cyc; b_wr = wr_cyc; b_d = d_pul;
      dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h2ABC;
      wait_resp(gi, gd);
      dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
      tick();
      chk("t3_wr_cycles", 128'(wr_cyc - b_wr), 128'd1);
      chk("t3_no_read", 128'(rd_cyc - b_rd), 128'd0);
      chk("t3_addr", 128'(mon_addr), 128'h2AB0);
      chk("t3_d_pulses", 128'(d_pul - b_d), 128'd1);

      // D inputs change while SERVE_D
      lat = 4; l2_data = D5;
      b_wr = wr_cyc;
      dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h3010; dcache_pmem_wdata = W1;
      wait_req();
      dcache_pmem_address = 16'h4444; dcache_pmem_wdata = W2; dcache_pmem_write = 1'b1;
      wait_resp(gi, gd);
      chk("t4_addr_held", 128'(l2arb_mem_address), 128'h3010);
      dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
      tick();
      chk("t4_mon_addr", 128'(mon_addr), 128'h3010);
      chk("t4_wdata_held", mon_wdata, W1);
      chk("t4_no_write", 128'(wr_cyc - b_wr), 128'd0);
      chk("t4_drdata", dcache_pmem_rdata, D5);
      chk("t4_irdata_other", icache_pmem_rdata, A5);

      // Both requesting continuously right after reset
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      lat = 1; l2_data = W1;
      b_v = viol;
      seq = '0;
      icache_pmem_read = 1'b1; icache_pmem_address = 16'h0100;
      dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0200;
      for (int n = 0; n < 4; n++) begin
         wait_resp(gi, gd);
         seq = {seq[2:0], gd};
      end
      icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
      tick();
      chk("t5_order", 128'(seq), 128'b0101);
      chk("t5_respond_req_low", 128'(viol - b_v), 128'd0);

      // Reset during SERVE_I with resp pending, then reissue
      lat = 10; l2_data = C3;
      icache_pmem_read = 1'b1; icache_pmem_address = 16'h5678;
      wait_req();
      tick();
      b_i = i_pul;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctrl", 128'({l2arb_mem_read, l2arb_mem_write, icache_pmem_resp, dcache_pmem_resp}), 128'd0);
      chk("t6_rst_addr", 128'(l2arb_mem_address), 128'd0);
      chk("t6_rst_irdata", icache_pmem_rdata, 128'd0);
      tick(); tick();
      rst_n = 1'b1;
      lat = 2;
      wait_resp(gi, gd);
      chk("t6_gi", 128'(gi), 128'd1);
      chk("t6_irdata", icache_pmem_rdata, C3);
      chk("t6_single_pulse", 128'(i_pul - b_i), 128'd1);
      chk("t6_addr", 128'(l2arb_mem_address), 128'h5670);
      icache_pmem_read = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Sits between the two L1 caches (instruction and data) and the L2 cache controller's l2arb_* request port.
- Accepts line-sized miss/writeback requests from each L1.
- Grants one request at a time using round-robin, then registers the chosen address and write data.
- Drives a single read/write handshake into L2, and returns the L2 read line and a one-cycle response to the granted L1 only.

Parameters:
- ADDR_WIDTH, 16, byte-address width (lc3b_word).
- BLOCK_WIDTH, 128, cache line width in bits (lc3b_block).
- OFFSET_BITS, 4, line-offset bits forced to zero on the forwarded address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_pmem_read  in  1  I-cache line read request, level; held until icache_pmem_resp.
- icache_pmem_address  in  ADDR_WIDTH  I-cache request address.
- icache_pmem_rdata  out  BLOCK_WIDTH  line returned to I-cache.
- icache_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- dcache_pmem_read  in  1  D-cache line read request, level.
- dcache_pmem_write  in  1  D-cache line write request, level.
- dcache_pmem_address  in  ADDR_WIDTH  D-cache request address.
- dcache_pmem_wdata  in  BLOCK_WIDTH  D-cache writeback line.
- dcache_pmem_rdata  out  BLOCK_WIDTH  line returned to D-cache.
- dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- l2arb_mem_read  out  1  read request to L2.
- l2arb_mem_write  out  1  write request to L2.
- l2arb_mem_address  out  ADDR_WIDTH  registered, line-aligned address.
- l2arb_mem_wdata  out  BLOCK_WIDTH  registered write line.
- l2arb_mem_rdata  in  BLOCK_WIDTH  L2 read line, valid in the cycle l2arb_mem_resp=1.
- l2arb_mem_resp  in  1  L2 completion; single-cycle pulse.

Behaviour:
- Reset state:
  - All outputs 0; address, wdata and rdata registers 0.
  - State IDLE; last_grant = DCACHE, so the first tie goes to the I-cache.
- States: IDLE, SERVE_I, SERVE_D, RESPOND.
- IDLE:
  - req_i = icache_pmem_read; req_d = dcache_pmem_read | dcache_pmem_write.
  - If only one request is present, grant it. If both are present, grant the requester that is not last_grant.
  - On grant, register:
    - address with [OFFSET_BITS-1:0] cleared;
    - wdata (D only);
    - op: write if dcache_pmem_write, else read. If the D-cache asserts read and write together, it is treated as a write.
  - Update last_grant and go to SERVE_x.
  - No L2 request is driven in IDLE.
- SERVE_x:
  - Drive l2arb_mem_read or l2arb_mem_write per the registered op, holding address and wdata constant.
  - Remain in SERVE_x until l2arb_mem_resp. On resp, capture l2arb_mem_rdata into the granted requester's rdata register and go to RESPOND.
  - L1 input changes during SERVE_x are ignored; only the registered values are used.
- RESPOND (exactly 1 cycle):
  - l2arb_mem_read and l2arb_mem_write are 0, which lets L2 settle back to idle.
  - Pulse the granted L1's *_pmem_resp = 1 with its rdata register stable.
  - Next state is IDLE.
- Latency: minimum 1 (grant) + L2 latency + 1 (RESPOND) cycles from request to resp. The next grant is considered no earlier than the cycle after RESPOND.
- The non-granted requester's resp stays 0. Its rdata register holds its previous value.
- rdata registers are written only on capture; they persist after resp.
- Fairness: with both L1s requesting continuously, grants strictly alternate and neither waits more than one full transaction.
- Reset asserted mid-transaction:
  - Immediate return to the reset state and L2 request deasserted.
  - No resp pulse is issued. The L1s must reissue their requests.
- An l2arb_mem_resp arriving in IDLE or RESPOND is ignored.

Decomposition:
- lc3b_types supplies lc3b_word and lc3b_block.
- Add to that package: an enum type with values ARB_I and ARB_D for the grant/last_grant encoding.
- One sub-module, l2_arbiter_rr: the round-robin pick.
  - Inputs: req_i, req_d, last_grant.
  - Output: grant_valid, grant_sel.
  - Combinational; last_grant is held in the parent.
- The FSM and datapath registers stay in l2_arbiter.

Test Plan:
- I-only read of 0x1234 with L2 resp after 3 cycles and rdata=0xA5..A5:
  - l2arb_mem_address=0x1230 and l2arb_mem_read held 3 cycles.
  - icache_pmem_resp pulses once with rdata=0xA5..A5; dcache_pmem_resp stays 0.
- D write to 0x2008 with wdata=0x0123..CDEF:
  - l2arb_mem_write=1, address=0x2000, wdata matches.
  - dcache_pmem_resp pulses 1 cycle after l2arb_mem_resp.
  - l2arb_mem_read never asserts.
- Both requesting every cycle right after reset:
  - Grant order is I, D, I, D over 4 transactions.
  - L2 request is low in every RESPOND cycle.
- D read and write asserted together: a single write transaction is issued.
- Change dcache address/wdata during SERVE_D: l2arb_mem_address and l2arb_mem_wdata keep their registered values.
- rst_n low during SERVE_I with L2 resp pending:
  - All outputs 0 immediately and state IDLE; no icache_pmem_resp.
  - After release, I-cache reissue is served normally.
